// File: rtl/ah_func_sched.sv
// ---------------------------------------------------------------------------
// ah_func_sched
//
// Batch scheduler in front of the fixed-latency ah_func datapath. A batch of
// N operands is accepted one per cycle from the requester and driven on
// pipe_dataa_o. A tag shift register marks which datapath slots carry a real
// operand, so the matching pipe_result_i can be captured into an output FIFO
// LATENCY cycles later. The datapath cannot stall, so issue is gated by
// credits: an operand is only accepted when a FIFO entry is guaranteed to be
// free for its result (inflight + fifo_count < DEPTH).
//
// Ports
//   clk_i          rising-edge clock
//   reset_i        asynchronous, active-high reset
//   start_i        single-cycle batch start, sampled only in IDLE
//   n_items_i      batch length, latched on start
//   busy_o         high while a batch is running or draining
//   done_o         one-cycle pulse when a batch completes
//   in_valid_i     requester operand valid
//   in_data_i      operand (IEEE-754 single precision)
//   in_ready_o     operand accepted this cycle when in_valid_i is high
//   pipe_dataa_o   registered operand to the datapath
//   pipe_result_i  datapath result
//   out_valid_o    FIFO head valid
//   out_data_o     FIFO head (zero when empty)
//   out_ready_i    consumer pops the FIFO head
// ---------------------------------------------------------------------------
module ah_func_sched #(
    parameter int LATENCY = 51,
    parameter int DEPTH   = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] n_items_i,
    output logic             busy_o,
    output logic             done_o,
    input  logic             in_valid_i,
    input  logic [31:0]      in_data_i,
    output logic             in_ready_o,
    output logic [31:0]      pipe_dataa_o,
    input  logic [31:0]      pipe_result_i,
    output logic             out_valid_o,
    output logic [31:0]      out_data_o,
    input  logic             out_ready_i
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Occupancy counters must represent the value DEPTH itself.
    localparam int FC_W = $clog2(DEPTH + 1);
    localparam logic [FC_W:0]   DEPTH_W = (FC_W + 1)'(DEPTH);
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  n_q;
    logic [CNT_W-1:0]  issued_q;
    logic [CNT_W-1:0]  popped_q;
    logic [FC_W-1:0]   inflight_q;
    logic [FC_W-1:0]   fifo_count_q;
    logic [LATENCY:0]  tag_q;
    logic [31:0]       pipe_dataa_q;
    logic              done_q, done_d;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [31:0]       mem [DEPTH];

    logic              issue;
    logic              fifo_wr;
    logic              fifo_pop;
    logic              last_issue;
    logic              last_pop;
    logic              credit_ok;
    logic              start_idle;

    // -----------------------------------------------------------------------
    // Handshake terms
    // -----------------------------------------------------------------------
    assign start_idle = (state_q == S_IDLE) && start_i;
    assign issue      = in_valid_i && in_ready_o;
    // The slot leaving the last tag stage carries a real result this cycle.
    assign fifo_wr    = tag_q[LATENCY];
    assign fifo_pop   = out_valid_o && out_ready_i;
    assign last_issue = issue && ((issued_q + CNT_W'(1)) == n_q);
    assign last_pop   = fifo_pop && ((popped_q + CNT_W'(1)) == n_q);
    // Every operand in flight already owns a FIFO slot, so only a pop
    // actually returns a credit.
    assign credit_ok  = (({1'b0, inflight_q} + {1'b0, fifo_count_q}) < DEPTH_W);

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (n_items_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (last_issue) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_pop) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        busy_o     = (state_q == S_RUN) || (state_q == S_DRAIN);
        in_ready_o = (state_q == S_RUN) && (issued_q < n_q) && credit_ok;
        done_o     = done_q;
    end

    // -----------------------------------------------------------------------
    // Batch counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            n_q      <= '0;
            issued_q <= '0;
            popped_q <= '0;
        end else if (start_idle) begin
            n_q      <= n_items_i;
            issued_q <= '0;
            popped_q <= '0;
        end else begin
            if (issue) begin
                issued_q <= issued_q + CNT_W'(1);
            end
            if (fifo_pop) begin
                popped_q <= popped_q + CNT_W'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Credit bookkeeping
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            inflight_q   <= '0;
            fifo_count_q <= '0;
        end else begin
            case ({issue, fifo_wr})
                2'b10:   inflight_q <= inflight_q + FC_W'(1);
                2'b01:   inflight_q <= inflight_q - FC_W'(1);
                default: inflight_q <= inflight_q;
            endcase
            case ({fifo_wr, fifo_pop})
                2'b10:   fifo_count_q <= fifo_count_q + FC_W'(1);
                2'b01:   fifo_count_q <= fifo_count_q - FC_W'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Operand register and slot tags. Clearing the tags on reset is what
    // discards results of an abandoned batch still inside the datapath.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pipe_dataa_q <= '0;
            tag_q        <= '0;
        end else begin
            if (issue) begin
                pipe_dataa_q <= in_data_i;
            end
            tag_q <= {tag_q[LATENCY-1:0], issue};
        end
    end

    assign pipe_dataa_o = pipe_dataa_q;

    // -----------------------------------------------------------------------
    // Result FIFO (first-word fall-through). Storage is written without
    // reset; validity comes solely from fifo_count_q.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (fifo_wr) begin
            mem[wr_ptr_q] <= pipe_result_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr_q <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
            end
        end
    end

    assign out_valid_o = (fifo_count_q != '0);
    // Forced to zero when empty so reset leaves a clean output bus.
    assign out_data_o  = out_valid_o ? mem[rd_ptr_q] : 32'h0;

endmodule

// File: tb/tb_ah_func_sched.sv
// ---------------------------------------------------------------------------
// tb_ah_func_sched
//
// Directed bench for ah_func_sched. Two instances are built: DEPTH=64 and
// DEPTH=8 (credit-limited). A select signal routes the shared stimulus to one
// of them and muxes its outputs back. Each instance has its own datapath
// model: a LATENCY-deep delay line computing x ^ 32'h5A5A5A5A.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ah_func_sched;

    localparam int          LAT = 51;
    localparam logic [31:0] KEY = 32'h5A5A5A5A;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sel;
    logic        start;
    logic [15:0] n_items;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        busy_a, done_a, in_ready_a, out_valid_a;
    logic [31:0] pipe_a, res_a, out_a;
    logic        busy_b, done_b, in_ready_b, out_valid_b;
    logic [31:0] pipe_b, res_b, out_b;

    ah_func_sched #(.LATENCY(LAT), .DEPTH(64), .CNT_W(16)) u_dut64 (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (start & ~sel),
        .n_items_i    (n_items),
        .busy_o       (busy_a),
        .done_o       (done_a),
        .in_valid_i   (in_valid & ~sel),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready_a),
        .pipe_dataa_o (pipe_a),
        .pipe_result_i(res_a),
        .out_valid_o  (out_valid_a),
        .out_data_o   (out_a),
        .out_ready_i  (out_ready & ~sel)
    );

    ah_func_sched #(.LATENCY(LAT), .DEPTH(8), .CNT_W(16)) u_dut8 (
        .clk_i        (clk),
        .reset_i      (rst),
        .start_i      (start & sel),
        .n_items_i    (n_items),
        .busy_o       (busy_b),
        .done_o       (done_b),
        .in_valid_i   (in_valid & sel),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready_b),
        .pipe_dataa_o (pipe_b),
        .pipe_result_i(res_b),
        .out_valid_o  (out_valid_b),
        .out_data_o   (out_b),
        .out_ready_i  (out_ready & sel)
    );

    // Datapath models
    logic [31:0] dl_a [LAT];
    logic [31:0] dl_b [LAT];
    always @(posedge clk) begin
        dl_a[0] <= pipe_a ^ KEY;
        dl_b[0] <= pipe_b ^ KEY;
        for (int i = 1; i < LAT; i++) begin
            dl_a[i] <= dl_a[i-1];
            dl_b[i] <= dl_b[i-1];
        end
    end
    assign res_a = dl_a[LAT-1];
    assign res_b = dl_b[LAT-1];

    // Observed outputs of the selected instance
    logic        busy, done, in_ready, out_valid;
    logic [31:0] pipe_dataa, out_data;
    assign busy       = sel ? busy_b      : busy_a;
    assign done       = sel ? done_b      : done_a;
    assign in_ready   = sel ? in_ready_b  : in_ready_a;
    assign out_valid  = sel ? out_valid_b : out_valid_a;
    assign pipe_dataa = sel ? pipe_b      : pipe_a;
    assign out_data   = sel ? out_b       : out_a;

    // Bookkeeping
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [31:0] src [128];
    int          n_src, next_in, next_out;
    int          acc_cnt, out_cnt, done_cnt;
    int          first_acc, last_acc, first_out, last_out;
    int          acc_at_first_out, done_cyc;
    logic        busy_at_done;
    logic        iv_en, ordy_en;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic new_batch(input int n, input int seed);
        logic [31:0] s;
        s = 32'(seed);
        n_src = n;
        for (int i = 0; i < n; i++) begin
            src[i] = {s[7:0], 8'h3C, 16'(i)} ^ 32'h40490FDB;
        end
        next_in = 0;   next_out = 0;
        acc_cnt = 0;   out_cnt = 0;   done_cnt = 0;
        first_acc = -1; last_acc = -1; first_out = -1; last_out = -1;
        acc_at_first_out = -1; done_cyc = -1; busy_at_done = 1'bx;
    endtask

    // One clock cycle: drive inputs, score the handshakes, advance.
    task automatic tick();
        in_valid  = iv_en && (next_in < n_src);
        in_data   = in_valid ? src[next_in] : 32'hDEADBEEF;
        out_ready = ordy_en;
        if (done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = busy;
        end
        if (out_valid && out_ready) begin
            if (next_out < n_src) begin
                chk($sformatf("result[%0d]", next_out), out_data, src[next_out] ^ KEY);
            end else begin
                chk("extra_result", 32'd1, 32'd0);
            end
            if (out_cnt == 0) begin
                first_out        = cyc;
                acc_at_first_out = acc_cnt;
            end
            last_out = cyc;
            out_cnt++;
            next_out++;
        end
        if (in_valid && in_ready) begin
            if (acc_cnt == 0) first_acc = cyc;
            last_acc = cyc;
            acc_cnt++;
            next_in++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic start_batch(input int n);
        start   = 1'b1;
        n_items = 16'(n);
        tick();
        start   = 1'b0;
        n_items = 16'h0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < bound) begin
            tick();
            k++;
        end
        chk(tag, 32'(done_cnt != d0), 32'd1);
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; start = 1'b0; n_items = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        iv_en = 1'b0; ordy_en = 1'b0;
        new_batch(0, 0);
        repeat (3) @(posedge clk);
        #1;
        // ---- reset state ----
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_pipe",      pipe_dataa,     32'd0);
        rst = 1'b0;
        tick(); tick();

        // ---- latency: N=1, x=0x3F800000 ----
        new_batch(1, 0);
        src[0] = 32'h3F800000;
        ordy_en = 1'b1;
        start_batch(1);
        chk("lat_busy_run",  32'(busy),     32'd1);
        chk("lat_in_ready",  32'(in_ready), 32'd1);
        iv_en = 1'b1;
        tick();
        chk("lat_pipe_dataa", pipe_dataa, 32'h3F800000);
        wait_done("lat_done_seen", 200);
        chk("lat_first_out", 32'(first_out - first_acc), 32'd53);
        chk("lat_out_cnt",   32'(out_cnt), 32'd1);
        chk("lat_done_after_pop", 32'(done_cyc - last_out), 32'd1);
        chk("lat_busy_at_done", 32'(busy_at_done), 32'd0);
        chk("lat_done_low",  32'(done), 32'd0);
        chk("lat_busy_low",  32'(busy), 32'd0);
        chk("lat_pipe_hold", pipe_dataa, 32'h3F800000);

        // ---- full throughput: DEPTH=64, N=20 ----
        new_batch(20, 1);
        iv_en = 1'b1; ordy_en = 1'b1;
        start_batch(20);
        wait_done("thr_done_seen", 300);
        chk("thr_acc_cnt",   32'(acc_cnt), 32'd20);
        chk("thr_acc_span",  32'(last_acc - first_acc), 32'd19);
        chk("thr_out_cnt",   32'(out_cnt), 32'd20);
        chk("thr_out_span",  32'(last_out - first_out), 32'd19);
        chk("thr_latency",   32'(first_out - first_acc), 32'd53);
        chk("thr_done_cnt",  32'(done_cnt), 32'd1);

        // ---- credit limit: DEPTH=8, N=20 ----
        sel = 1'b1;
        new_batch(20, 2);
        iv_en = 1'b1; ordy_en = 1'b1;
        start_batch(20);
        wait_done("cred_done_seen", 1500);
        chk("cred_acc_before_out", 32'(acc_at_first_out), 32'd8);
        chk("cred_acc_cnt",  32'(acc_cnt), 32'd20);
        chk("cred_out_cnt",  32'(out_cnt), 32'd20);
        chk("cred_done_cnt", 32'(done_cnt), 32'd1);
        sel = 1'b0;

        // ---- backpressure: DEPTH=64, N=100, out_ready low ----
        new_batch(100, 3);
        iv_en = 1'b1; ordy_en = 1'b0;
        start_batch(100);
        repeat (200) tick();
        chk("bp_acc_cnt",    32'(acc_cnt),   32'd64);
        chk("bp_in_ready",   32'(in_ready),  32'd0);
        chk("bp_out_valid",  32'(out_valid), 32'd1);
        chk("bp_out_cnt",    32'(out_cnt),   32'd0);
        ordy_en = 1'b1;
        wait_done("bp_done_seen", 2000);
        chk("bp_acc_total",  32'(acc_cnt),  32'd100);
        chk("bp_out_total",  32'(out_cnt),  32'd100);
        repeat (3) tick();
        chk("bp_out_empty",  32'(out_valid), 32'd0);
        chk("bp_done_cnt",   32'(done_cnt),  32'd1);

        // ---- N=0 start, then start on the done pulse ----
        new_batch(2, 4);
        iv_en = 1'b1; ordy_en = 1'b1;
        start_batch(0);
        chk("n0_done",  32'(done), 32'd1);
        chk("n0_busy",  32'(busy), 32'd0);
        start_batch(2);
        chk("n0_next_busy", 32'(busy), 32'd1);
        chk("n0_next_done", 32'(done), 32'd0);
        wait_done("n0_batch_done", 300);
        chk("n0_out_cnt", 32'(out_cnt), 32'd2);
        chk("n0_acc_cnt", 32'(acc_cnt), 32'd2);

        // ---- start during RUN is ignored ----
        new_batch(8, 5);
        iv_en = 1'b0; ordy_en = 1'b1;
        start_batch(4);
        tick();
        start_batch(5);
        chk("ign_busy", 32'(busy), 32'd1);
        iv_en = 1'b1;
        wait_done("ign_done_seen", 300);
        repeat (3) tick();
        chk("ign_acc_cnt",  32'(acc_cnt),  32'd4);
        chk("ign_out_cnt",  32'(out_cnt),  32'd4);
        chk("ign_done_cnt", 32'(done_cnt), 32'd1);

        // ---- asynchronous reset mid-batch ----
        new_batch(10, 6);
        iv_en = 1'b1; ordy_en = 1'b1;
        start_batch(10);
        begin
            int k;
            k = 0;
            while (acc_cnt < 6 && k < 100) begin
                tick();
                k++;
            end
        end
        chk("rstm_acc_cnt", 32'(acc_cnt), 32'd6);
        chk("rstm_pipe_pre", pipe_dataa, src[5]);
        iv_en = 1'b0;
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rstm_busy",      32'(busy),      32'd0);
        chk("rstm_in_ready",  32'(in_ready),  32'd0);
        chk("rstm_out_valid", 32'(out_valid), 32'd0);
        chk("rstm_out_data",  out_data,       32'd0);
        chk("rstm_pipe",      pipe_dataa,     32'd0);
        chk("rstm_done",      32'(done),      32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        new_batch(0, 7);
        ordy_en = 1'b1;
        repeat (80) tick();
        chk("rstm_stale_outs", 32'(out_cnt), 32'd0);
        new_batch(3, 8);
        iv_en = 1'b1;
        start_batch(3);
        wait_done("rstm_new_done", 300);
        chk("rstm_new_out_cnt", 32'(out_cnt), 32'd3);
        chk("rstm_new_acc_cnt", 32'(acc_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
